// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one single-cycle combinational ALU between NUM_REQ requesters.
// A round-robin arbiter picks one valid request in IDLE. Its opcode and
// operands are latched and presented to the ALU during EXEC. The ALU result
// is captured into rsp_data and held in RESP until the owning requester
// accepts it. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n   : clock and synchronous active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept (one-hot or zero, IDLE only)
//   req_op       : packed opcodes, requester i uses [4i+3:4i]
//   req_a, req_b : packed operands, requester i uses [32i+31:32i]
//   alu_rs1/rs2  : latched operands to the ALU
//   alu_op       : latched opcode to the ALU
//   alu_result   : combinational result from the ALU
//   rsp_valid    : per-requester response valid (one-hot or zero)
//   rsp_ready    : per-requester response accept (only the owner's bit counts)
//   rsp_data     : registered ALU result, shared by all requesters
//   busy         : high whenever a transaction is in flight
//   grant_id     : index of the current or most recent owner
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*4-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [31:0]             alu_rs1,
  output logic [31:0]             alu_rs2,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic            found;
  logic [31:0]     a_q, b_q;
  logic [3:0]      op_q;

  // Unpacked views of the request payloads, indexed by requester.
  logic [3:0]      op_arr [NUM_REQ];
  logic [31:0]     a_arr  [NUM_REQ];
  logic [31:0]     b_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[4*g +: 4];
    assign a_arr[g]  = req_a[32*g +: 32];
    assign b_arr[g]  = req_b[32*g +: 32];
  end

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and keep the first valid one.
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && found) req_ready[win]   = 1'b1;
    if (state == RESP)          rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand/opcode registers are reset as well as the control
      // state so the ALU never sees stale data after a reset mid-transaction.
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rsp_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state <= state_nxt;
      if (state == IDLE && found) begin
        a_q    <= a_arr[win];
        b_q    <= b_arr[win];
        op_q   <= op_arr[win];
        owner  <= win;
        // The pointer moves past the winner only when a grant happens.
        rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == EXEC) rsp_data <= alu_result;
    end
  end

  // ALU inputs come straight from the latches so they stay stable outside EXEC.
  assign alu_rs1  = a_q;
  assign alu_rs2  = b_q;
  assign alu_op   = op_q;
  assign busy     = (state != IDLE);
  assign grant_id = IDW'(owner);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives a four-requester alu_arbiter with directed scenarios followed by a
// randomized phase. A stand-in ALU answers alu_result. A transaction-level
// model predicts every output each cycle; directed scenarios add literal
// expectations for the key values.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h2;
  localparam logic [3:0] OP_PASS = 4'h3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*4-1:0]    req_op = '0;
  logic [N*32-1:0]   req_a = '0;
  logic [N*32-1:0]   req_b = '0;
  logic [31:0]       alu_rs1, alu_rs2, alu_result;
  logic [3:0]        alu_op;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [31:0]       rsp_data;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  alu_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_PASS: return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_rs1, alu_rs2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: one outstanding transaction with an age counter.
  // ---------------------------------------------------------------------------
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  bit          m_busy;
  int          m_age;
  int          m_ptr;
  int          m_owner;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_data;
  int          m_win;

  assign m_win = pick(req_valid, m_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_ptr <= 0; m_owner <= 0;
      m_op <= '0; m_a <= '0; m_b <= '0; m_data <= '0;
    end else if (!m_busy) begin
      if (m_win >= 0) begin
        m_owner <= m_win;
        m_op    <= req_op[4*m_win +: 4];
        m_a     <= req_a[32*m_win +: 32];
        m_b     <= req_b[32*m_win +: 32];
        m_ptr   <= (m_win + 1) % N;
        m_busy  <= 1'b1;
        m_age   <= 0;
      end
    end else if (m_age == 0) begin
      m_age  <= 1;
      m_data <= alu_f(m_op, m_a, m_b);
    end else if (rsp_ready[m_owner]) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req_ready", 32'(req_ready),
            (!m_busy && m_win >= 0) ? (32'd1 << m_win) : 32'd0);
      check("m_rsp_valid", 32'(rsp_valid),
            (m_busy && m_age >= 1) ? (32'd1 << m_owner) : 32'd0);
      check("m_rsp_data", rsp_data, m_data);
      check("m_busy",     32'(busy), 32'(m_busy));
      check("m_grant_id", 32'(grant_id), 32'(m_owner));
      check("m_alu_rs1",  alu_rs1, m_a);
      check("m_alu_rs2",  alu_rs2, m_b);
      check("m_alu_op",   32'(alu_op), 32'(m_op));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_op[4*i +: 4]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input logic [N-1:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(input logic [N-1:0] exp_v, input logic [31:0] exp_d,
                          input string name);
    int n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(rsp_valid), 32'(exp_v));
    check({name, "_data"}, rsp_data, exp_d);
  endtask

  initial begin
    logic [N-1:0] acc;

    // Reset state.
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id",  32'(grant_id), 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);

    // Single ADD from requester 0 with rsp_ready already high.
    step();
    rsp_ready = '1;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    wait_accept(4'b0001, "t1_accept");
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_exec_busy",  32'(busy), 32'd1);
    check("t1_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid",  32'(rsp_valid), 32'd1);
    check("t1_rsp_data",   rsp_data, 32'd12);
    @(negedge clk);
    check("t1_idle_busy",  32'(busy), 32'd0);

    // Two continuous requesters alternate.
    do_reset();
    rsp_ready = '1;
    set_req(0, OP_SUB, 32'd10, 32'd3);
    set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_accept((k % 2 == 0) ? 4'b0001 : 4'b0010, "t2_grant");
      wait_rsp((k % 2 == 0) ? 4'b0001 : 4'b0010, (k % 2 == 0) ? 32'd7 : 32'd1, "t2_rsp");
    end
    step();
    req_valid = '0;

    // Response backpressure; non-owner rsp_ready bits must be ignored.
    step();
    rsp_ready = '0;
    set_req(0, OP_ADD, 32'd100, 32'd23);
    set_req(1, OP_SUB, 32'd50, 32'd8);
    wait_accept(4'b0001, "t3_grant0");
    step();
    req_valid[0] = 1'b0;
    wait_rsp(4'b0001, 32'd123, "t3_rsp0");
    step();
    rsp_ready = 4'b1110;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_data",  rsp_data, 32'd123);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 4'b0001;
    @(negedge clk);
    check("t3_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("t3_idle_busy",  32'(busy), 32'd0);
    check("t3_next_grant", 32'(req_ready), 32'b0010);
    step();
    rsp_ready = '1;
    req_valid[1] = 1'b0;
    wait_rsp(4'b0010, 32'd42, "t3_rsp1");
    step();

    // Pointer wrap: grant 2 alone (pointer -> 3), then 1 and 3 compete.
    do_reset();
    rsp_ready = '1;
    set_req(2, OP_PASS, 32'd0, 32'h55);
    wait_accept(4'b0100, "t4_grant2");
    step();
    req_valid = '0;
    wait_rsp(4'b0100, 32'h55, "t4_rsp2");
    step();
    set_req(1, OP_ADD, 32'd1, 32'd1);
    set_req(3, OP_SUB, 32'd9, 32'd4);
    wait_accept(4'b1000, "t4_grant3");
    wait_rsp(4'b1000, 32'd5, "t4_rsp3");
    wait_accept(4'b0010, "t4_grant1");
    step();
    req_valid = '0;
    wait_rsp(4'b0010, 32'd2, "t4_rsp1");

    // Reset during EXEC.
    step();
    rsp_ready = '0;
    set_req(0, OP_ADD, 32'd3, 32'd4);
    wait_accept(4'b0001, "t5_grant_a");
    step();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("t5_exec_busy", 32'(busy), 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_x_busy",  32'(busy), 32'd0);
    check("t5_x_valid", 32'(rsp_valid), 32'd0);
    check("t5_x_data",  rsp_data, 32'd0);
    @(negedge clk);
    check("t5_x_noresp", 32'(rsp_valid), 32'd0);

    // Reset during RESP.
    step();
    set_req(0, OP_ADD, 32'd3, 32'd4);
    wait_accept(4'b0001, "t5_grant_b");
    step();
    req_valid = '0;
    wait_rsp(4'b0001, 32'd7, "t5_rsp_b");
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_resp_hold", 32'(rsp_valid), 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_r_busy",  32'(busy), 32'd0);
    check("t5_r_valid", 32'(rsp_valid), 32'd0);
    check("t5_r_data",  rsp_data, 32'd0);

    // After reset the pointer is 0; PASS and an unknown opcode.
    step();
    rsp_ready = '1;
    set_req(0, OP_PASS, 32'd0, 32'hDEAD_BEEF);
    set_req(1, 4'hF, 32'd1, 32'd2);
    wait_accept(4'b0001, "t6_grant0");
    wait_rsp(4'b0001, 32'hDEAD_BEEF, "t6_pass");
    wait_accept(4'b0010, "t6_grant1");
    step();
    req_valid = '0;
    wait_rsp(4'b0010, 32'd0, "t6_unknown");
    step();

    // Randomized traffic obeying the request protocol.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          int r;
          r = int'($urandom_range(0, 5));
          if ($urandom_range(0, 2) == 0)
            set_req(i, (r < 4) ? 4'(r) : 4'($urandom),
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom);
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 4'($urandom);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
